// File: rtl/alu_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipelined
// Description : Registered ALU with valid/ready handshakes on input and output.
//               Eight ops: AND, OR, ADD, SUB, XOR, SLT, SLL and an iterative
//               shift-add MUL that takes WIDTH cycles. Result and flags sit in
//               an output register until the consumer takes them.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               in_valid / in_ready  - request handshake (opcode, a, b)
//               out_valid / out_ready- result handshake
//               out, carry, zero, negative, overflow - registered result/flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipelined #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       state_q,    state_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0] mplier_q,   mplier_d;
  logic [WIDTH-1:0] mcand_q,    mcand_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q,      out_d;
  logic             carry_q,    carry_d;
  logic             zero_q,     zero_d;
  logic             negative_q, negative_d;
  logic             overflow_q, overflow_d;

  logic busy;
  logic accept;

  assign busy     = (state_q == ST_MUL_BUSY);
  assign in_ready = !busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   addsub;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;

  // SUB reuses the adder as a + ~b + 1; carry-out of 1 means no borrow.
  assign is_sub = (opcode == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign addsub = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (opcode)
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_ADD, OP_SUB: begin
        sc_res   = addsub[WIDTH-1:0];
        sc_carry = addsub[WIDTH];
        // Signed overflow: like-signed operands producing an opposite sign.
        sc_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (addsub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: sc_res = a ^ b;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: sc_res = a << b[SHAMT_W-1:0];
      default: sc_res = '0;
    endcase
  end

  // One shift-add step of the iterative multiplier.
  logic [WIDTH-1:0] acc_step;
  assign acc_step = mcand_q[0] ? (acc_q + mplier_q) : acc_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;

    // A delivered result frees the register; a same-edge load overrides below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d  = ST_MUL_BUSY;
            count_d  = '0;
            acc_d    = '0;
            mplier_d = a;
            mcand_d  = b;
          end else begin
            out_valid_d = 1'b1;
            out_d       = sc_res;
            carry_d     = sc_carry;
            overflow_d  = sc_ovf;
            zero_d      = (sc_res == '0);
            negative_d  = sc_res[WIDTH-1];
          end
        end
      end
      ST_MUL_BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_q << 1;
        mcand_d  = mcand_q >> 1;
        // The WIDTH-th step is the final one and lands straight in the
        // output register, giving a fixed WIDTH-cycle latency.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d     = ST_IDLE;
          count_d     = '0;
          out_valid_d = 1'b1;
          out_d       = acc_step;
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = (acc_step == '0);
          negative_d  = acc_step[WIDTH-1];
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipelined
// Description : Directed self-checking bench for alu_pipelined (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipelined;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  alu_pipelined #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge, then withdraw it.
  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    tick();
    in_valid = 1'b0;
    opcode   = 3'b000;
    a        = '0;
    b        = '0;
  endtask

  // Wait for out_valid with a bounded number of cycles.
  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z,
                           input logic n, input logic v);
    chk({tag, "_flags"}, {60'd0, carry, zero, negative, overflow},
        {60'd0, c, z, n, v});
  endtask

  initial begin
    logic saw_valid;

    reset     = 1'b1;
    in_valid  = 1'b0;
    opcode    = 3'b000;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out", {32'd0, out}, 64'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ADD wrap to zero
    do_op(3'b010, 32'hFFFF_FFFF, 32'd1);
    chk("add_valid", {63'd0, out_valid}, 64'd1);
    chk("add_out", {32'd0, out}, 64'h0);
    chk_flags("add", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("add_valid_drop", {63'd0, out_valid}, 64'd0);

    // SUB with signed overflow
    do_op(3'b011, 32'h8000_0000, 32'd1);
    chk("sub1_out", {32'd0, out}, 64'h7FFF_FFFF);
    chk_flags("sub1", 1'b1, 1'b0, 1'b0, 1'b1);

    // SUB with borrow (back-to-back acceptance)
    do_op(3'b011, 32'd3, 32'd5);
    chk("sub2_valid", {63'd0, out_valid}, 64'd1);
    chk("sub2_out", {32'd0, out}, 64'hFFFF_FFFE);
    chk_flags("sub2", 1'b0, 1'b0, 1'b1, 1'b0);

    do_op(3'b101, 32'hFFFF_FFFF, 32'd0);
    chk("slt_out", {32'd0, out}, 64'd1);
    chk_flags("slt", 1'b0, 1'b0, 1'b0, 1'b0);

    do_op(3'b101, 32'd5, 32'hFFFF_FFFF);
    chk("slt2_out", {32'd0, out}, 64'd0);
    chk_flags("slt2", 1'b0, 1'b1, 1'b0, 1'b0);

    do_op(3'b110, 32'd1, 32'h23);
    chk("sll_out", {32'd0, out}, 64'h8);

    do_op(3'b100, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
    chk("xor_out", {32'd0, out}, 64'h0F0F_0F0F);

    do_op(3'b001, 32'h0000_00F0, 32'h0000_000F);
    chk("or_out", {32'd0, out}, 64'hFF);
    tick();

    // MUL: fixed latency, new request held off while busy
    do_op(3'b111, 32'h0001_2345, 32'h10);
    chk("mul_busy_e", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1;
    opcode   = 3'b010;
    a        = 32'd7;
    b        = 32'd8;
    for (int i = 1; i < 32; i++) begin
      tick();
      chk($sformatf("mul_busy_%0d", i), {62'd0, in_ready, out_valid}, 64'd0);
    end
    tick();
    chk("mul_valid", {63'd0, out_valid}, 64'd1);
    chk("mul_out", {32'd0, out}, 64'h0012_3450);
    chk_flags("mul", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("held_add_out", {32'd0, out}, 64'd15);
    tick();

    do_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid("mul2", 40);
    chk("mul2_out", {32'd0, out}, 64'd1);
    chk_flags("mul2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Backpressure hold, then same-edge reload
    out_ready = 1'b0;
    do_op(3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0);
    in_valid = 1'b1;
    opcode   = 3'b001;
    a        = 32'd1;
    b        = 32'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_out_%0d", i), {32'd0, out}, 64'h0F00_0F00);
      chk($sformatf("bp_hs_%0d", i), {62'd0, out_valid, in_ready}, 64'b10);
      chk_flags($sformatf("bp_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_reload_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_reload_out", {32'd0, out}, 64'd3);
    tick();
    chk("bp_drain", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of a MUL
    do_op(3'b111, 32'd5, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_out", {32'd0, out}, 64'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    chk("mrst_no_stale", {63'd0, saw_valid}, 64'd0);
    do_op(3'b010, 32'd2, 32'd3);
    chk("mrst_add_out", {32'd0, out}, 64'd5);
    chk_flags("mrst_add", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
